// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler for the 32-entry register file: round-robin sharing of the
// single write port between NUM_REQ requesters, plus a pending-write scoreboard.
module regfile_wb_scheduler #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_reg,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      reserve_valid,
  input  logic [ADDR_W-1:0]         reserve_reg,
  input  logic [ADDR_W-1:0]         rs1,
  input  logic [ADDR_W-1:0]         rs2,
  output logic                      rs1_busy,
  output logic                      rs2_busy,
  output logic                      regwrite,
  output logic [ADDR_W-1:0]         write_reg,
  output logic [DATA_W-1:0]         write_data,
  output logic [31:0]               busy_mask
);

  localparam int unsigned PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned NUM_REGS = 32;

  logic [ADDR_W-1:0]   reg_a  [NUM_REQ];
  logic [DATA_W-1:0]   data_a [NUM_REQ];

  logic [PTR_W-1:0]    rr_ptr_q;
  logic                regwrite_q;
  logic [ADDR_W-1:0]   write_reg_q;
  logic [DATA_W-1:0]   write_data_q;
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  logic                found_c;
  logic [PTR_W-1:0]    gnt_idx_c;
  logic [NUM_REQ-1:0]  grant_c;
  logic [ADDR_W-1:0]   sel_reg_c;
  logic [DATA_W-1:0]   sel_data_c;
  int unsigned         cand;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign reg_a[i]  = req_reg[i*ADDR_W +: ADDR_W];
    assign data_a[i] = req_data[i*DATA_W +: DATA_W];
  end

  // Round-robin search starting one past the last winner.
  always_comb begin
    found_c   = 1'b0;
    gnt_idx_c = rr_ptr_q;
    cand      = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(rr_ptr_q) + k) % NUM_REQ;
      if (!found_c && req_valid[PTR_W'(cand)]) begin
        found_c   = 1'b1;
        gnt_idx_c = PTR_W'(cand);
      end
    end
    grant_c = '0;
    if (found_c && !reset) begin
      grant_c[gnt_idx_c] = 1'b1;
    end
  end

  assign sel_reg_c  = reg_a[gnt_idx_c];
  assign sel_data_c = data_a[gnt_idx_c];

  // A reservation landing on the same edge as the commit wins.
  always_comb begin
    busy_d = busy_q;
    if (regwrite_q) begin
      busy_d[write_reg_q] = 1'b0;
    end
    if (reserve_valid && (reserve_reg != '0)) begin
      busy_d[reserve_reg] = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr_q     <= PTR_W'(NUM_REQ - 1);
      regwrite_q   <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      busy_q       <= '0;
    end else begin
      busy_q <= busy_d;
      if (found_c) begin
        rr_ptr_q     <= gnt_idx_c;
        regwrite_q   <= (sel_reg_c != '0);
        write_reg_q  <= sel_reg_c;
        write_data_q <= sel_data_c;
      end else begin
        regwrite_q   <= 1'b0;
      end
    end
  end

  assign req_ready  = grant_c;
  assign regwrite   = regwrite_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign busy_mask  = busy_q;
  assign rs1_busy   = busy_q[rs1] & (rs1 != '0);
  assign rs2_busy   = busy_q[rs2] & (rs2 != '0);

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed vectors, a behavioural model checked
// every cycle, and hand-computed literal expectations for key cycles.
module tb_regfile_wb_scheduler;

  localparam int unsigned N  = 2;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic            clock;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_reg;
  logic [N*DW-1:0] req_data;
  logic            reserve_valid;
  logic [AW-1:0]   reserve_reg;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            regwrite;
  logic [AW-1:0]   write_reg;
  logic [DW-1:0]   write_data;
  logic [31:0]     busy_mask;

  regfile_wb_scheduler #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_reg(req_reg), .req_data(req_data),
    .reserve_valid(reserve_valid), .reserve_reg(reserve_reg),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .regwrite(regwrite), .write_reg(write_reg), .write_data(write_data),
    .busy_mask(busy_mask)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural model: last winner, the pending write, and the set of pending registers.
  int          m_last;
  logic        m_rw;
  logic [AW-1:0] m_wreg;
  logic [DW-1:0] m_wdata;
  logic [31:0] m_busy;

  function automatic int winner(input int last, input logic [N-1:0] v);
    for (int k = 1; k <= int'(N); k++) begin
      if (v[(last + k) % int'(N)]) return (last + k) % int'(N);
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] r;
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] pending_after(input logic [31:0] b, input logic rw,
      input logic [AW-1:0] wr, input logic rv, input logic [AW-1:0] rr);
    logic [31:0] nb;
    nb = b;
    if (rw) nb[wr] = 1'b0;
    if (rv && rr != 0) nb[rr] = 1'b1;
    return nb;
  endfunction

  function automatic logic [AW-1:0] reg_of(input int g);
    logic [N*AW-1:0] t;
    t = req_reg;
    return t[g*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] data_of(input int g);
    logic [N*DW-1:0] t;
    t = req_data;
    return t[g*DW +: DW];
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_last  <= int'(N) - 1;
      m_rw    <= 1'b0;
      m_wreg  <= '0;
      m_wdata <= '0;
      m_busy  <= '0;
    end else begin
      m_busy <= pending_after(m_busy, m_rw, m_wreg, reserve_valid, reserve_reg);
      if (winner(m_last, req_valid) >= 0) begin
        m_last  <= winner(m_last, req_valid);
        m_rw    <= (reg_of(winner(m_last, req_valid)) != 0);
        m_wreg  <= reg_of(winner(m_last, req_valid));
        m_wdata <= data_of(winner(m_last, req_valid));
      end else begin
        m_rw    <= 1'b0;
      end
    end
  end

  // Literal expectations posted by the stimulus for the coming falling edge.
  logic          l_rdy_en, l_wr_en, l_busy_en, l_rs1_en, l_rs2_en;
  logic [N-1:0]  l_rdy;
  logic          l_rw;
  logic [AW-1:0] l_wreg;
  logic [DW-1:0] l_wdata;
  logic [31:0]   l_busy;
  logic          l_rs1, l_rs2;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    chk("ready",      64'(req_ready),  64'(reset ? '0 : onehot(winner(m_last, req_valid))));
    chk("regwrite",   64'(regwrite),   64'(m_rw));
    chk("write_reg",  64'(write_reg),  64'(m_wreg));
    chk("write_data", 64'(write_data), 64'(m_wdata));
    chk("busy_mask",  64'(busy_mask),  64'(m_busy));
    chk("rs1_busy",   64'(rs1_busy),   64'(m_busy[rs1] && rs1 != 0));
    chk("rs2_busy",   64'(rs2_busy),   64'(m_busy[rs2] && rs2 != 0));
    if (l_rdy_en)  chk("lit_ready", 64'(req_ready), 64'(l_rdy));
    if (l_wr_en) begin
      chk("lit_regwrite",   64'(regwrite),   64'(l_rw));
      chk("lit_write_reg",  64'(write_reg),  64'(l_wreg));
      chk("lit_write_data", 64'(write_data), 64'(l_wdata));
    end
    if (l_busy_en) chk("lit_busy_mask", 64'(busy_mask), 64'(l_busy));
    if (l_rs1_en)  chk("lit_rs1_busy",  64'(rs1_busy),  64'(l_rs1));
    if (l_rs2_en)  chk("lit_rs2_busy",  64'(rs2_busy),  64'(l_rs2));
  end

  task automatic cyc();
    @(posedge clock);
    #1;
    l_rdy_en = 0; l_wr_en = 0; l_busy_en = 0; l_rs1_en = 0; l_rs2_en = 0;
  endtask

  task automatic idle();
    req_valid = '0;
    reserve_valid = 1'b0;
  endtask

  task automatic req(input logic [N-1:0] v, input logic [AW-1:0] r0, input logic [DW-1:0] d0,
                     input logic [AW-1:0] r1, input logic [DW-1:0] d1);
    req_valid = v;
    req_reg   = {r1, r0};
    req_data  = {d1, d0};
  endtask

  task automatic reserve(input logic v, input logic [AW-1:0] r);
    reserve_valid = v;
    reserve_reg   = r;
  endtask

  task automatic exp_rdy(input logic [N-1:0] r);
    l_rdy_en = 1; l_rdy = r;
  endtask

  task automatic exp_wr(input logic rw, input logic [AW-1:0] r, input logic [DW-1:0] d);
    l_wr_en = 1; l_rw = rw; l_wreg = r; l_wdata = d;
  endtask

  task automatic exp_busy(input logic [31:0] b);
    l_busy_en = 1; l_busy = b;
  endtask

  initial begin
    l_rdy_en = 0; l_wr_en = 0; l_busy_en = 0; l_rs1_en = 0; l_rs2_en = 0;
    l_rdy = '0; l_rw = 0; l_wreg = '0; l_wdata = '0; l_busy = '0; l_rs1 = 0; l_rs2 = 0;
    reset = 1'b0;
    req_valid = '0; req_reg = '0; req_data = '0;
    reserve_valid = 1'b0; reserve_reg = '0; rs1 = '0; rs2 = '0;
    #1 reset = 1'b1;

    cyc(); exp_rdy('0); exp_wr(0, 0, 0); exp_busy(0);
    cyc(); reset = 1'b0;

    // Single request from requester 0.
    cyc(); req(2'b01, 5, 32'hDEADBEEF, 0, 0); exp_rdy(2'b01);
    cyc(); idle(); exp_wr(1, 5, 32'hDEADBEEF);

    // Reset lands while a write is registered: dropped immediately, ready forced low.
    cyc(); req(2'b10, 0, 0, 9, 32'h12345678); reserve(1, 9); exp_rdy(2'b10);
    cyc(); reserve(0, 0); reset = 1'b1; exp_rdy('0); exp_wr(0, 0, 0); exp_busy(0);
    cyc(); idle(); reset = 1'b0; exp_wr(0, 0, 0); exp_busy(0);
    cyc(); exp_wr(0, 0, 0);

    // Both requesters held for six cycles: alternate grants from requester 0.
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (i == 0) req(2'b11, 3, 32'hA0A00003, 7, 32'hA1A10007);
      exp_rdy((i % 2 == 0) ? 2'b01 : 2'b10);
      if (i > 0) begin
        if (i % 2 == 1) exp_wr(1, 3, 32'hA0A00003);
        else            exp_wr(1, 7, 32'hA1A10007);
      end
    end
    cyc(); idle(); exp_wr(1, 7, 32'hA1A10007);

    // Scoreboard: busy visible the cycle after reserve, clears the cycle after commit.
    cyc(); reserve(1, 9); rs1 = 9; l_rs1_en = 1; l_rs1 = 0;
    cyc(); reserve(0, 0); req(2'b10, 0, 0, 9, 32'h00000099);
    exp_rdy(2'b10); l_rs1_en = 1; l_rs1 = 1; exp_busy(32'h0000_0200);
    cyc(); idle(); exp_wr(1, 9, 32'h00000099); l_rs1_en = 1; l_rs1 = 1;
    cyc(); l_rs1_en = 1; l_rs1 = 0; exp_busy(0);

    // x0: accepted, no write, pointer still advances.
    cyc(); req(2'b01, 0, 32'hFFFFFFFF, 0, 0); exp_rdy(2'b01);
    cyc(); idle(); exp_wr(0, 0, 32'hFFFFFFFF);
    cyc(); req(2'b11, 3, 32'hA0A00003, 7, 32'hA1A10007); exp_rdy(2'b10);
    cyc(); idle(); exp_wr(1, 7, 32'hA1A10007);

    // Reserve colliding with the commit of the same register keeps it busy.
    cyc(); reserve(1, 12); req(2'b01, 12, 32'h0000C0DE, 0, 0); rs2 = 12;
    exp_rdy(2'b01); l_rs2_en = 1; l_rs2 = 0;
    cyc(); req_valid = '0; exp_wr(1, 12, 32'h0000C0DE); exp_busy(32'h0000_1000);
    l_rs2_en = 1; l_rs2 = 1;
    cyc(); reserve(0, 0); exp_wr(0, 12, 32'h0000C0DE); exp_busy(32'h0000_1000);
    l_rs2_en = 1; l_rs2 = 1;
    cyc(); exp_busy(32'h0000_1000);
    cyc();
    @(negedge clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
